instruction_refill_responder: RTL
=================================

# instruction_refill_responder

Backing-store responder that answers instruction-cache line refill requests. Accepts one 29-bit block address per valid/ready handshake, waits a programmable latency, then returns the 32-bit instruction word held for that block. Sits below the instruction cache as the memory end of its miss path and replaces the fixed 32'hDEAD_BEEF miss fill with real program contents. Contents are preloaded through a write port by the testbench or boot logic.

## Interface
Parameters:
- DEPTH, 256: words of storage; power of two, at least 2.
- LATENCY, 4: cycles from request accept to response valid; at least 1.
- BASE_BLOCK, 29'h00000020: block address (PC[31:3]) stored at word 0.

Ports:
- clock  in  1  main clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- req_valid  in  1  refill request present.
- req_ready  out  1  responder can accept a request.
- req_block  in  29  requested block address.
- resp_valid  out  1  response word valid.
- resp_ready  in  1  cache consumes the response.
- resp_block  out  29  block address of the current response.
- resp_data  out  32  instruction word.
- resp_error  out  1  request was out of range (see Configuration).
- load_en  in  1  write the preload word this cycle.
- load_index  in  $clog2(DEPTH)  preload word index.
- load_data  in  32  preload word.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: capture req_block, set cnt=LATENCY-1, go to WAIT.
- WAIT: req_ready=0. If cnt==0, read the array, register resp_data, resp_block and resp_error, and go to RESP. Otherwise decrement cnt.
- RESP: resp_valid=1. resp_data, resp_block and resp_error stay stable until resp_ready. On resp_ready, go to IDLE.
- Index computation: offset = captured_block - BASE_BLOCK, as an unsigned 29-bit subtract. Blocks below BASE_BLOCK wrap to a large offset.
- Load port: the write is independent of FSM state and takes effect at posedge.
- Simultaneous load to the index being read on the WAIT→RESP edge: the response carries the old word (read-before-write).
- A load in any earlier WAIT cycle is visible in the response.
- Array contents are not reset.
- req_valid while req_ready=0 is ignored. The requester must hold the request.
- resp_ready outside RESP is ignored.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_block=0, resp_error=0, cnt=0.
- Reset asserted mid-WAIT or mid-RESP aborts the request; no response is issued.
- Accept at edge E0 → resp_valid high after edge E0+LATENCY.
- With resp_ready held high, resp_valid lasts one cycle and req_ready returns after edge E0+LATENCY+1.
- Minimum request period: LATENCY+2 cycles.
- resp_ready low holds RESP indefinitely with all outputs stable.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: IMEM_RANGE_CHECK_EN.
- Defined: an offset at or above DEPTH returns resp_data=32'hDEAD_BEEF and resp_error=1; the array is not read. In-range requests give resp_error=0.
- Undefined: index = offset[$clog2(DEPTH)-1:0], so the address aliases modulo DEPTH. resp_error is constant 0.

## Test plan
- Reset then idle: req_ready=1, resp_valid=0, resp_data=0 for 5 cycles. Assert reset mid-WAIT → resp_valid never rises and req_ready=1 after release.
- Preload index 3 = 32'hF8400281. Request block 29'h23 with resp_ready=1 → resp_valid after exactly 4 edges, resp_data=32'hF8400281, resp_block=29'h23, resp_error=0.
- Backpressure: same request with resp_ready low for 6 cycles → outputs stable and req_ready=0 throughout. Raise resp_ready → IDLE next edge.
- Back-to-back: requests 29'h20, 29'h21, 29'h22 held valid → accepts spaced 6 cycles apart, responses in order with the matching words.
- Load collision: request index 5. Load index 5 = 32'h11111111 in the first WAIT cycle → response 32'h11111111. Repeat, loading 32'h22222222 on the WAIT→RESP edge → response 32'h11111111.
- Out of range, block 29'h1F and block 29'h120 (DEPTH=256):
  - IMEM_RANGE_CHECK_EN defined → 32'hDEAD_BEEF with resp_error=1 for both.
  - Undefined → 29'h120 returns the word at index 0 with resp_error=0.

Source files
------------

// File: rtl/instruction_refill_responder.sv
// Instruction refill responder: answers one block-address request with the stored word after LATENCY cycles; optional IMEM_RANGE_CHECK_EN.
// Latency: resp_valid rises LATENCY edges after the accepting edge; one request in flight, period LATENCY+2 when resp_ready is held.
// Backpressure: response registers hold in RESP until resp_ready; req_ready is low from accept until the response is consumed.
module instruction_refill_responder #(
    parameter int          DEPTH      = 256,
    parameter int          LATENCY    = 4,
    parameter logic [28:0] BASE_BLOCK = 29'h00000020
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [28:0]              req_block,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [28:0]              resp_block,
    output logic [31:0]              resp_data,
    output logic                     resp_error,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [31:0]              load_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          nextState;
    logic [CW-1:0]   cnt;
    logic [28:0]     capturedBlock;
    logic [AW-1:0]   readIndex;
    logic            outOfRange;
    logic            accept;
    logic            issue;
    logic [31:0]     mem [DEPTH];

    assign accept = (state == IDLE) && req_valid;
    assign issue  = (state == WAIT) && (cnt == '0);

`ifdef IMEM_RANGE_CHECK_EN
    logic [28:0] offset;
    // Full-width subtract so blocks below BASE_BLOCK wrap high and fail the range test.
    assign offset     = capturedBlock - BASE_BLOCK;
    assign readIndex  = offset[AW-1:0];
    assign outOfRange = (offset >= 29'(DEPTH));
`else
    // Only the low bits matter when aliasing modulo DEPTH.
    assign readIndex  = capturedBlock[AW-1:0] - BASE_BLOCK[AW-1:0];
    assign outOfRange = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid)  nextState = WAIT;
            WAIT:    if (cnt == '0)  nextState = RESP;
            RESP:    if (resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            capturedBlock <= '0;
            resp_block    <= '0;
            resp_data     <= '0;
            resp_error    <= 1'b0;
        end else begin
            if (accept) begin
                capturedBlock <= req_block;
                cnt           <= CW'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (issue) begin
                resp_block <= capturedBlock;
                resp_error <= outOfRange;
                resp_data  <= outOfRange ? 32'hDEAD_BEEF : mem[readIndex];
            end
        end
    end

    // Storage is deliberately unreset; a load on the issue edge is seen only by later requests.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_index] <= load_data;
        end
    end

endmodule
